// File: rtl/fulladder_checker_if.sv
// Adder-under-test bus: operands and carry-in out, sum and carry-out back.
// The checker is the master; the adder (or its model) is the slave.
interface fulladder_checker_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output a,
    output b,
    output c,
    input  sum,
    input  carry
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output sum,
    output carry
  );
endinterface

// File: rtl/fulladder_checker.sv
// Exhaustive self-checking sweep of an adder: drives every {a,b,c}
// vector, compares {carry,sum} to a+b+c and logs the first failure.
module fulladder_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  fulladder_checker_if.master    adder,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic                   fail_valid,
  output logic [2*WIDTH:0]       first_fail
);
  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t          state;
  logic [VW-1:0]   v;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  expected;
  logic [WIDTH:0]  got;
  logic            mismatch;
  logic            last;
  logic [ERR_W-1:0] err_next;

  assign expected = {1'b0, adder.a}
                  + {1'b0, adder.b}
                  + (WIDTH+1)'(adder.c);
  assign got      = {adder.carry, adder.sum};
  assign mismatch = (got != expected);
  assign last     = &v;

  // Count saturates so a long run of failures never wraps to "pass".
  assign err_next = (mismatch && !(&err_count))
                  ? err_count + 1'b1
                  : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      cnt        <= '0;
      adder.a    <= '0;
      adder.b    <= '0;
      adder.c    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            v          <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end
        APPLY: begin
          adder.a <= v[VW-1 -: WIDTH];
          adder.b <= v[WIDTH:1];
          adder.c <= v[0];
          cnt     <= '0;
          state   <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (cnt == CW'(SETTLE - 1)) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= v;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            v     <= v + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fulladder_checker.sv
// Bench: five checkers against behavioural adders with injectable faults,
// table of fault scenarios plus reset-abort and start-glitch sequences.
module tb_fulladder_checker;
  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  bit [31:0] mask;
  int   checks = 0;
  int   failures = 0;
  int   busy_cyc[5];

  always #5 clk = ~clk;

  fulladder_checker_if #(.WIDTH(1)) bus0 ();
  fulladder_checker_if #(.WIDTH(1)) bus1 ();
  fulladder_checker_if #(.WIDTH(1)) bus2 ();
  fulladder_checker_if #(.WIDTH(1)) bus3 ();
  fulladder_checker_if #(.WIDTH(2)) bus4 ();

  logic busy[5], done[5], pass[5], fv[5];
  logic [7:0] e0, e2, e3, e4;
  logic [1:0] e1;
  logic [2:0] f0, f1, f2, f3;
  logic [4:0] f4;

  // Adder with optional fault: 1 carry stuck 0, 2 sum inverted,
  // 3 sum lsb flipped on vectors selected by mask.
  function automatic int fa_out(int w, int md, bit [31:0] m,
                                int a, int b, int c);
    int r;
    int v;
    r = a + b + c;
    v = (a << (w + 1)) | (b << 1) | c;
    case (md)
      1: r = r & ((1 << w) - 1);
      2: r = r ^ ((1 << w) - 1);
      3: if (m[v]) r = r ^ 1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic void ref_run(int w, int errw, int md, bit [31:0] m,
                                  output int err, output int first,
                                  output bit fvo);
    int n;
    int cnt;
    int a, b, c;
    n = 1 << (2 * w + 1);
    cnt = 0;
    first = 0;
    fvo = 1'b0;
    for (int v = 0; v < n; v++) begin
      a = v >> (w + 1);
      b = (v >> 1) & ((1 << w) - 1);
      c = v & 1;
      if (fa_out(w, md, m, a, b, c) != a + b + c) begin
        cnt++;
        if (!fvo) begin
          fvo = 1'b1;
          first = v;
        end
      end
    end
    err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
  endfunction

  logic [1:0] r0, r1, r2, r3;
  logic [2:0] r4;
  assign r0 = 2'(fa_out(1, mode, mask, int'(bus0.a), int'(bus0.b), int'(bus0.c)));
  assign r1 = 2'(fa_out(1, mode, mask, int'(bus1.a), int'(bus1.b), int'(bus1.c)));
  assign r2 = 2'(fa_out(1, mode, mask, int'(bus2.a), int'(bus2.b), int'(bus2.c)));
  assign r3 = 2'(fa_out(1, mode, mask, int'(bus3.a), int'(bus3.b), int'(bus3.c)));
  assign r4 = 3'(fa_out(2, mode, mask, int'(bus4.a), int'(bus4.b), int'(bus4.c)));
  assign {bus0.carry, bus0.sum} = r0;
  assign {bus1.carry, bus1.sum} = r1;
  assign {bus2.carry, bus2.sum} = r2;
  assign {bus3.carry, bus3.sum} = r3;
  assign {bus4.carry, bus4.sum} = r4;

  fulladder_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(8)) d0 (
    .clk(clk), .rst(rst), .start(start), .adder(bus0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(e0), .fail_valid(fv[0]), .first_fail(f0));
  fulladder_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(2)) d1 (
    .clk(clk), .rst(rst), .start(start), .adder(bus1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(e1), .fail_valid(fv[1]), .first_fail(f1));
  fulladder_checker #(.WIDTH(1), .SETTLE(0), .ERR_W(8)) d2 (
    .clk(clk), .rst(rst), .start(start), .adder(bus2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(e2), .fail_valid(fv[2]), .first_fail(f2));
  fulladder_checker #(.WIDTH(1), .SETTLE(3), .ERR_W(8)) d3 (
    .clk(clk), .rst(rst), .start(start), .adder(bus3),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .err_count(e3), .fail_valid(fv[3]), .first_fail(f3));
  fulladder_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(8)) d4 (
    .clk(clk), .rst(rst), .start(start), .adder(bus4),
    .busy(busy[4]), .done(done[4]), .pass(pass[4]),
    .err_count(e4), .fail_valid(fv[4]), .first_fail(f4));

  typedef struct {
    int        md;
    bit [31:0] m;
    int        err;
    int        err2;
    int        first;
    bit        fvx;
  } row_t;

  row_t tbl[7];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit all_done();
    return done[0] && done[1] && done[2] && done[3] && done[4];
  endfunction

  task automatic sweep(input int glitch);
    busy_cyc = '{default: 0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_clear",
        int'({done[0], pass[0], fv[0], e0 != 8'd0, f0 != 3'd0}), 0);
    for (int t = 0; t < 300; t++) begin
      if (all_done()) break;
      for (int k = 0; k < 5; k++) busy_cyc[k] += int'(busy[k]);
      if (t == glitch) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("sweep_timeout", int'(all_done()), 1);
  endtask

  task automatic check_row(input row_t r, input string tag);
    int err4, first4;
    bit fv4;
    ref_run(2, 8, r.md, r.m, err4, first4, fv4);
    chk({tag, "_cyc_s1"}, busy_cyc[0], 24);
    chk({tag, "_cyc_e2"}, busy_cyc[1], 24);
    chk({tag, "_cyc_s0"}, busy_cyc[2], 16);
    chk({tag, "_cyc_s3"}, busy_cyc[3], 40);
    chk({tag, "_cyc_w2"}, busy_cyc[4], 96);
    chk({tag, "_err"}, int'(e0), r.err);
    chk({tag, "_first"}, int'(f0), r.first);
    chk({tag, "_fv"}, int'(fv[0]), int'(r.fvx));
    chk({tag, "_pass"}, int'(pass[0]), int'(r.err == 0));
    chk({tag, "_busy"}, int'(busy[0]), 0);
    chk({tag, "_abc"}, int'({bus0.a, bus0.b, bus0.c}), 7);
    chk({tag, "_err_sat"}, int'(e1), r.err2);
    chk({tag, "_first_sat"}, int'(f1), r.first);
    chk({tag, "_pass_sat"}, int'(pass[1]), int'(r.err2 == 0));
    chk({tag, "_err_s0"}, int'(e2), r.err);
    chk({tag, "_first_s0"}, int'({fv[2], f2}), int'({r.fvx, 3'(r.first)}));
    chk({tag, "_err_s3"}, int'(e3), r.err);
    chk({tag, "_first_s3"}, int'({fv[3], f3}), int'({r.fvx, 3'(r.first)}));
    chk({tag, "_err_w2"}, int'(e4), err4);
    chk({tag, "_first_w2"}, int'({fv[4], f4}), int'({fv4, 5'(first4)}));
    chk({tag, "_pass_w2"}, int'(pass[4]), int'(err4 == 0));
    chk({tag, "_abc_w2"}, int'({bus4.a, bus4.b, bus4.c}), 31);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    mask = '0;

    tbl[0] = '{0, 32'h0,  0, 0, 0, 1'b0};
    tbl[1] = '{1, 32'h0,  4, 3, 3, 1'b1};
    tbl[2] = '{2, 32'h0,  8, 3, 0, 1'b1};
    tbl[3] = '{3, 32'h80, 1, 1, 7, 1'b1};
    tbl[4] = '{3, 32'h01, 1, 1, 0, 1'b1};
    for (int i = 5; i < 7; i++) begin
      tbl[i].md = 3;
      tbl[i].m  = $urandom();
      ref_run(1, 8, 3, tbl[i].m, tbl[i].err, tbl[i].first, tbl[i].fvx);
      ref_run(1, 2, 3, tbl[i].m, tbl[i].err2, tbl[i].first, tbl[i].fvx);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        int'({busy[0], done[0], pass[0], e0, fv[0], f0,
              bus0.a, bus0.b, bus0.c}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].md;
      mask = tbl[i].m;
      sweep(-1);
      check_row(tbl[i], $sformatf("row%0d", i));
    end

    // start while busy is ignored; start in DONE repeats the result
    mode = tbl[1].md;
    mask = tbl[1].m;
    sweep(5);
    check_row(tbl[1], "glitch");
    sweep(-1);
    check_row(tbl[1], "rerun");

    // synchronous reset aborts a sweep mid-flight
    mode = 0;
    mask = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", int'(busy[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_clear",
        int'({busy[0], done[0], pass[0], e0, fv[0], f0,
              bus0.a, bus0.b, bus0.c}), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle", int'({busy[0], done[0]}), 0);
    sweep(-1);
    check_row(tbl[0], "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
